hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO register pair of the pipelined core. It sits beside the EX stage and executes mult/multu/div/divu over multiple cycles. It exposes `busy` so hazard logic stalls mfhi/mflo until results are ready. It also accepts mthi/mtlo writes and reports divide-by-zero.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits; must be ≥ 4 and even.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  launch operation; sampled only when busy=0.
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- src_a  in  WIDTH  multiplicand / dividend (rs).
- src_b  in  WIDTH  multiplier / divisor (rt).
- mthi  in  1  write wdata into HI.
- mtlo  in  1  write wdata into LO.
- wdata  in  WIDTH  data for mthi/mtlo.
- hi  out  WIDTH  HI register (mfhi source).
- lo  out  WIDTH  LO register (mflo source).
- busy  out  1  operation in flight; pipeline stalls mfhi/mflo/mthi/mtlo/new muldiv.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_by_zero  out  1  set when a div/divu with src_b=0 completes; cleared on next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; hi, lo, busy, done and div_by_zero are all 0. Reset mid-operation aborts it with no HI/LO update.
- State machine:
  - IDLE: on start, latch operands and op, clear div_by_zero, and go to RUN.
  - RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - FIX: sign correction, write hi/lo, done=1, return to IDLE.
- busy is registered and equals (state != IDLE).
- Latency: start sampled at edge 0.
  - busy=1 after edges 0..WIDTH+1.
  - hi/lo are valid after edge WIDTH+2, with done=1 and busy=0 in that same cycle.
  - Total: WIDTH+2 cycles (34 for WIDTH=32).
- Signed operations take absolute values on entry and record the result signs.
- Multiply: shift-add over magnitudes producing a 2*WIDTH-bit product. FIX negates it if the signs differ. hi=product[2W-1:W], lo=product[W-1:0].
- Divide: radix-2 restoring over magnitudes.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero: lo = all ones, hi = src_a (as latched), div_by_zero=1. Timing is unchanged.
- Signed overflow (MIN / -1): lo=MIN, hi=0, no flag.
- start while busy=1 is ignored; no queueing.
- mthi/mtlo:
  - In IDLE with no start, the register is written at the edge. mthi and mtlo may be written together.
  - While busy=1 they are ignored; the pipeline must stall them.
  - mthi/mtlo in the same cycle as start: the write is applied at edge 0 and then overwritten at completion.
- hi/lo hold their values at all other times; they are never partially updated during RUN.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: when an accepted start has src_b=0, or op is mult/multu with src_a=0, the unit skips RUN and goes IDLE→FIX. Results are valid after edge 1, with done pulsing in that cycle. Result values are identical to the full path; div_by_zero behaves the same.
- Undefined: every operation takes the full WIDTH+2 cycles.

Test Plan:
- WIDTH=32, divu src_a=100, src_b=7 → after 34 cycles lo=0x0000000E, hi=0x00000002, done one pulse, busy high for exactly 34 cycles.
- div src_a=0xFFFFFFF9 (-7), src_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Follow with mfhi then mflo reads: hazard logic holds them until busy=0; the values read are hi then lo.
- mult 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div 0x12345678/0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. With MULDIV_EARLY_OUT_EN, done comes 1 cycle after start. A following start clears div_by_zero.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0. Signed MIN/-1 with no divide-by-zero flag.
- mtlo 0xAAAA5555 in IDLE, then start divu 9/3. Assert a second start and mthi 0x1 during RUN; both are ignored. Assert rst_n=0 at cycle 10: hi=lo=0, busy=0, done never pulses.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative mult/multu/div/divu unit that owns the HI/LO pair. Define MULDIV_EARLY_OUT_EN
// to let zero divisors and zero multiplicands skip the iteration phase.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic               is_signed, is_div, b_zero, early_out;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum, div_trial;
  logic [WIDTH-1:0]   rem_shift, rem_fix, quo_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];
  assign b_zero    = (b_q == '0);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply: acc holds {partial sum, remaining multiplier bits}, shifted right each step.
  assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc holds {remainder, dividend/quotient}, shifted left each step.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign rem_shift = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (src_b == '0) || (!op[1] && (src_a == '0));
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          op_d      = op;
          a_d       = src_a;
          b_d       = src_b;
          opnd_d    = '0;
          acc_d     = '0;
          neg_res_d = 1'b0;
          neg_rem_d = 1'b0;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          state_d   = early_out ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          // First RUN cycle loads magnitudes and result signs.
          opnd_d    = is_div ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          neg_res_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_d = is_signed && a_q[WIDTH-1];
        end else if (is_div) begin
          acc_d = {(div_trial[WIDTH] ? rem_shift : div_trial[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          acc_d = {mult_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        dbz_d   = is_div && b_zero;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
